// File: rtl/pong_engine.sv
// Pong game-state engine: ball, paddles, scores and serve/play/point/over sequencing.
// Every output is a register that updates on the clk edge of the causing event; no flow control.
module pong_engine #(
    parameter int PADDLE_H    = 8,
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 16,
    parameter int P1_X        = 1,
    parameter int P2_X        = 62
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       start,
    input  logic       p1_up,
    input  logic       p1_dn,
    input  logic       p2_up,
    input  logic       p2_dn,
    output logic [5:0] bx,
    output logic [5:0] by,
    output logic [5:0] p1y,
    output logic [5:0] p2y,
    output logic [2:0] sc1,
    output logic [2:0] sc2,
    output logic       game_over,
    output logic       winner
);

    localparam logic [5:0] CENTER     = 6'd31;
    localparam logic [5:0] PAD_TOP    = 6'd28;
    localparam logic [5:0] EDGE_MAX   = 6'd63;
    localparam logic [5:0] PAD_MAX    = 6'(64 - PADDLE_H);
    localparam logic [5:0] P1_HIT_X   = 6'(P1_X + 1);
    localparam logic [5:0] P2_HIT_X   = 6'(P2_X - 1);
    localparam logic [7:0] SERVE_INIT = 8'(SERVE_DELAY - 1);
    localparam logic [2:0] WIN        = 3'(WIN_SCORE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] bx_q, bx_d;
    logic [5:0] by_q, by_d;
    logic [5:0] p1y_q, p1y_d;
    logic [5:0] p2y_q, p2y_d;
    logic [2:0] sc1_q, sc1_d;
    logic [2:0] sc2_q, sc2_d;
    logic       game_over_q, game_over_d;
    logic       winner_q, winner_d;
    logic       dx_q, dx_d;             // 1 = moving right (+1)
    logic       dy_q, dy_d;             // 1 = moving down (+1)
    logic       serve_dy_q, serve_dy_d;
    logic [7:0] cnt_q, cnt_d;

    logic [5:0] by_n;
    logic       dy_n;
    logic       hit1, hit2;
    logic       pt1, pt2;
    logic       win_now;

    function automatic logic [5:0] paddle_next(input logic [5:0] y, input logic up,
                                               input logic dn);
        paddle_next = y;
        if (up && !dn && y != 6'd0) begin
            paddle_next = y - 6'd1;
        end else if (dn && !up && y < PAD_MAX) begin
            paddle_next = y + 6'd1;
        end
    endfunction

    function automatic logic in_paddle(input logic [5:0] b, input logic [5:0] top);
        logic [6:0] bot;
        bot       = {1'b0, top} + 7'(PADDLE_H - 1);
        in_paddle = (b >= top) && ({1'b0, b} <= bot);
    endfunction

    always_comb begin
        state_d     = state_q;
        bx_d        = bx_q;
        by_d        = by_q;
        p1y_d       = p1y_q;
        p2y_d       = p2y_q;
        sc1_d       = sc1_q;
        sc2_d       = sc2_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        serve_dy_d  = serve_dy_q;
        cnt_d       = cnt_q;
        pt1         = 1'b0;
        pt2         = 1'b0;
        win_now     = 1'b0;
        hit1        = in_paddle(by_q, p1y_q);
        hit2        = in_paddle(by_q, p2y_q);

        // Vertical step with top/bottom bounce, applied only when no point is scored.
        dy_n = dy_q;
        if (!dy_q && by_q == 6'd0) begin
            dy_n = 1'b1;
            by_n = 6'd1;
        end else if (dy_q && by_q == EDGE_MAX) begin
            dy_n = 1'b0;
            by_n = EDGE_MAX - 6'd1;
        end else begin
            by_n = dy_q ? by_q + 6'd1 : by_q - 6'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SERVE;
                    dx_d    = 1'b1;
                    cnt_d   = SERVE_INIT;
                end
            end
            ST_SERVE: begin
                if (tick) begin
                    p1y_d = paddle_next(p1y_q, p1_up, p1_dn);
                    p2y_d = paddle_next(p2y_q, p2_up, p2_dn);
                    if (cnt_q == 8'd0) begin
                        state_d = ST_PLAY;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            ST_PLAY: begin
                if (tick) begin
                    p1y_d = paddle_next(p1y_q, p1_up, p1_dn);
                    p2y_d = paddle_next(p2y_q, p2_up, p2_dn);
                    if (!dx_q && bx_q == P1_HIT_X) begin
                        if (hit1) begin
                            dx_d = 1'b1;
                            bx_d = bx_q + 6'd1;
                        end else begin
                            bx_d = bx_q - 6'd1;
                        end
                    end else if (dx_q && bx_q == P2_HIT_X) begin
                        if (hit2) begin
                            dx_d = 1'b0;
                            bx_d = bx_q - 6'd1;
                        end else begin
                            bx_d = bx_q + 6'd1;
                        end
                    end else if (!dx_q && bx_q == 6'd0) begin
                        pt2 = 1'b1;
                    end else if (dx_q && bx_q == EDGE_MAX) begin
                        pt1 = 1'b1;
                    end else begin
                        bx_d = dx_q ? bx_q + 6'd1 : bx_q - 6'd1;
                    end

                    if (pt1 || pt2) begin
                        if (pt1) begin
                            sc1_d   = sc1_q + 3'd1;
                            win_now = (sc1_q + 3'd1) == WIN;
                        end else begin
                            sc2_d   = sc2_q + 3'd1;
                            win_now = (sc2_q + 3'd1) == WIN;
                        end
                        if (win_now) begin
                            state_d     = ST_OVER;
                            game_over_d = 1'b1;
                            winner_d    = pt2;
                        end else begin
                            // Re-serve toward the player who just conceded.
                            state_d    = ST_SERVE;
                            bx_d       = CENTER;
                            by_d       = CENTER;
                            dx_d       = pt1;
                            serve_dy_d = ~serve_dy_q;
                            dy_d       = ~serve_dy_q;
                            cnt_d      = SERVE_INIT;
                        end
                    end else begin
                        by_d = by_n;
                        dy_d = dy_n;
                    end
                end
            end
            ST_OVER: begin
                if (start) begin
                    state_d     = ST_SERVE;
                    sc1_d       = 3'd0;
                    sc2_d       = 3'd0;
                    game_over_d = 1'b0;
                    bx_d        = CENTER;
                    by_d        = CENTER;
                    dx_d        = 1'b1;
                    cnt_d       = SERVE_INIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bx_q        <= CENTER;
            by_q        <= CENTER;
            p1y_q       <= PAD_TOP;
            p2y_q       <= PAD_TOP;
            sc1_q       <= 3'd0;
            sc2_q       <= 3'd0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
            serve_dy_q  <= 1'b1;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            p1y_q       <= p1y_d;
            p2y_q       <= p2y_d;
            sc1_q       <= sc1_d;
            sc2_q       <= sc2_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            serve_dy_q  <= serve_dy_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bx        = bx_q;
    assign by        = by_q;
    assign p1y       = p1y_q;
    assign p2y       = p2y_q;
    assign sc1       = sc1_q;
    assign sc2       = sc2_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine: expectations are queued with the cycle they apply to
// and a negedge monitor pops and compares them. A field value of -1 means "don't care".
module tb_pong_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       p1_up = 1'b0;
    logic       p1_dn = 1'b0;
    logic       p2_up = 1'b0;
    logic       p2_dn = 1'b0;
    logic [5:0] bx, by, p1y, p2y;
    logic [2:0] sc1, sc2;
    logic       game_over, winner;

    always #5 clk = ~clk;

    pong_engine dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .start    (start),
        .p1_up    (p1_up),
        .p1_dn    (p1_dn),
        .p2_up    (p2_up),
        .p2_dn    (p2_dn),
        .bx       (bx),
        .by       (by),
        .p1y      (p1y),
        .p2y      (p2y),
        .sc1      (sc1),
        .sc2      (sc2),
        .game_over(game_over),
        .winner   (winner)
    );

    typedef struct {
        int cyc;
        int bx;
        int by;
        int p1y;
        int p2y;
        int sc1;
        int sc2;
        int go;
        int win;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic bit fld_bad(input int e, input int a);
        return (e >= 0) && (e != a);
    endfunction

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
            exp_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            tests++;
            if (fld_bad(e.bx, int'(bx)) || fld_bad(e.by, int'(by)) ||
                fld_bad(e.p1y, int'(p1y)) || fld_bad(e.p2y, int'(p2y)) ||
                fld_bad(e.sc1, int'(sc1)) || fld_bad(e.sc2, int'(sc2)) ||
                fld_bad(e.go, int'(game_over)) || fld_bad(e.win, int'(winner))) begin
                fails++;
                $display("FAIL %s: got bx=%0d by=%0d p1y=%0d p2y=%0d sc1=%0d sc2=%0d go=%0d win=%0d; expected bx=%0d by=%0d p1y=%0d p2y=%0d sc1=%0d sc2=%0d go=%0d win=%0d",
                         n, bx, by, p1y, p2y, sc1, sc2, game_over, winner,
                         e.bx, e.by, e.p1y, e.p2y, e.sc1, e.sc2, e.go, e.win);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One frame tick followed by one idle (tick=0) cycle.
    task automatic do_tick(input int n);
        repeat (n) begin
            tick = 1'b1;
            @(posedge clk);
            #1;
            tick = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string n, input int ebx, input int eby, input int ep1,
                       input int ep2, input int es1, input int es2, input int ego,
                       input int ewin);
        exp_t e;
        e.cyc = cyc_cnt;
        e.bx  = ebx;
        e.by  = eby;
        e.p1y = ep1;
        e.p2y = ep2;
        e.sc1 = es1;
        e.sc2 = es2;
        e.go  = ego;
        e.win = ewin;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick  = 1'b1;
        start = 1'b1;
        p1_up = 1'b0;
        p1_dn = 1'b0;
        p2_up = 1'b0;
        p2_dn = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        tick  = 1'b0;
        start = 1'b0;
        cyc(1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
    endtask

    initial begin
        int guard;

        // Reset and IDLE behaviour
        do_reset();
        chk("reset", 31, 31, 28, 28, 0, 0, 0, 0);
        p1_up = 1'b1;
        p2_dn = 1'b1;
        do_tick(3);
        chk("idle_buttons_ignored", 31, 31, 28, 28, 0, 0, 0, 0);
        p1_up = 1'b0;
        p2_dn = 1'b0;

        // Serve timing, then a right-side miss
        pulse_start();
        do_tick(15);
        chk("serve_t15", 31, 31, 28, 28, 0, 0, 0, 0);
        do_tick(1);
        chk("serve_t16", 31, 31, 28, 28, 0, 0, 0, 0);
        do_tick(1);
        chk("play_t1", 32, 32, 28, 28, 0, 0, 0, 0);
        do_tick(1);
        chk("play_t2", 33, 33, 28, 28, 0, 0, 0, 0);
        pulse_start();
        chk("start_ignored_play", 33, 33, 28, 28, 0, 0, 0, 0);
        do_tick(28);
        chk("play_t30", 61, 61, 28, 28, 0, 0, 0, 0);
        do_tick(1);
        chk("miss_t31", 62, 62, 28, 28, 0, 0, 0, 0);
        do_tick(1);
        chk("miss_t32", 63, 63, 28, 28, 0, 0, 0, 0);
        do_tick(1);
        chk("point_p1", 31, 31, 28, 28, 1, 0, 0, 0);
        do_tick(16);
        chk("reserve_hold", 31, 31, 28, 28, 1, 0, 0, 0);
        do_tick(1);
        chk("reserve_dir", 32, 30, 28, 28, 1, 0, 0, 0);

        // Reset while in PLAY, then confirm the engine sits in IDLE
        do_reset();
        chk("reset_in_play", 31, 31, 28, 28, 0, 0, 0, 0);
        do_tick(20);
        chk("idle_after_reset", 31, 31, 28, 28, 0, 0, 0, 0);

        // Paddle saturation
        pulse_start();
        p1_up = 1'b1;
        do_tick(40);
        chk("p1_sat_top", -1, -1, 0, 28, 0, 0, 0, -1);
        p1_up = 1'b0;
        p1_dn = 1'b1;
        do_tick(60);
        chk("p1_sat_bottom", 31, 31, 56, 28, 2, 0, 0, -1);
        p1_up = 1'b1;
        do_tick(5);
        chk("p1_both_hold", -1, -1, 56, 28, -1, 0, 0, -1);
        p1_up = 1'b0;
        p1_dn = 1'b0;

        // Right paddle hit, bottom bounce, left-side miss, left paddle hit, top bounce
        do_reset();
        p2_dn = 1'b1;
        pulse_start();
        do_tick(16);
        chk("hit_serve_p2", 31, 31, 28, 44, 0, 0, 0, 0);
        do_tick(30);
        chk("hit_t30", 61, 61, 28, 56, 0, 0, 0, 0);
        do_tick(1);
        chk("hit_t31", 60, 62, 28, 56, 0, 0, 0, 0);
        do_tick(1);
        chk("hit_t32", 59, 63, 28, 56, 0, 0, 0, 0);
        do_tick(1);
        chk("bounce_bottom", 58, 62, 28, 56, 0, 0, 0, 0);
        do_tick(56);
        chk("left_approach", 2, 6, 28, 56, 0, 0, 0, 0);
        do_tick(1);
        chk("left_miss", 1, 5, 28, 56, 0, 0, 0, 0);
        do_tick(1);
        chk("left_wall", 0, 4, 28, 56, 0, 0, 0, 0);
        do_tick(1);
        chk("point_p2", 31, 31, 28, 56, 0, 1, 0, 0);
        p2_dn = 1'b0;
        p1_up = 1'b1;
        do_tick(16);
        chk("serve_to_p1", 31, 31, 12, 56, 0, 1, 0, 0);
        do_tick(1);
        chk("serve_to_p1_dir", 30, 30, 11, 56, 0, 1, 0, 0);
        do_tick(28);
        chk("p1_approach", 2, 2, 0, 56, 0, 1, 0, 0);
        do_tick(1);
        chk("p1_hit", 3, 1, 0, 56, 0, 1, 0, 0);
        do_tick(1);
        chk("p1_hit_next", 4, 0, 0, 56, 0, 1, 0, 0);
        do_tick(1);
        chk("bounce_top", 5, 1, 0, 56, 0, 1, 0, 0);
        p1_up = 1'b0;

        // Seven P1 points end the game
        do_reset();
        pulse_start();
        for (int i = 1; i <= 6; i++) begin
            do_tick(49);
            chk($sformatf("p1_point_%0d", i), 31, 31, 28, 28, i, 0, 0, 0);
        end
        do_tick(48);
        chk("before_last_point", 63, 63, 28, 28, 6, 0, 0, 0);
        do_tick(1);
        chk("game_over", 63, 63, 28, 28, 7, 0, 1, 0);
        p1_up = 1'b1;
        p2_dn = 1'b1;
        do_tick(10);
        chk("over_hold", 63, 63, 28, 28, 7, 0, 1, 0);
        p1_up = 1'b0;
        p2_dn = 1'b0;
        pulse_start();
        chk("restart", 31, 31, 28, 28, 0, 0, 0, -1);
        do_tick(16);
        chk("restart_serve_hold", 31, 31, 28, 28, 0, 0, 0, -1);
        do_tick(1);
        chk("restart_play", 32, -1, 28, 28, 0, 0, 0, -1);

        guard = 0;
        while (exp_q.size() > 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pong_engine.md
Name: pong_engine

Overview:
Game-state engine for the 64x64 Pong display. Advances ball and paddle positions on each frame tick from player button inputs and keeps both scores. Runs the serve/play/point/game-over sequence. Drives bx, by, p1y, p2y, sc1 and sc2 directly into the downstream LED matrix renderer.

Parameters:
PADDLE_H, 8, paddle height in rows; p1y/p2y give the paddle's top row.
WIN_SCORE, 7, score that ends the game; range 1..7.
SERVE_DELAY, 16, frame ticks spent in SERVE before play starts; range 1..255.
P1_X, 1, column of the left paddle.
P2_X, 62, column of the right paddle.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
tick  input  1  one-cycle frame strobe; all motion happens only on cycles with tick=1
start  input  1  starts a new game; sampled every cycle while in IDLE or OVER
p1_up  input  1  left paddle up (toward row 0)
p1_dn  input  1  left paddle down
p2_up  input  1  right paddle up
p2_dn  input  1  right paddle down
bx  output  6  ball column
by  output  6  ball row
p1y  output  6  left paddle top row
p2y  output  6  right paddle top row
sc1  output  3  player 1 score
sc2  output  3  player 2 score
game_over  output  1  high while in OVER
winner  output  1  0 = P1, 1 = P2; valid only when game_over=1

Behaviour:
- All outputs are registered and update on the clk edge where the event occurs.
- Reset: if rst_n=0 at a clk edge, all state resets regardless of current state or tick. Reset values:
  - state IDLE
  - bx=31, by=31
  - p1y=p2y=28
  - sc1=sc2=0
  - game_over=0, winner=0
  - dx=+1, dy=+1, serve_dy=+1
- Internal state: direction bits dx/dy (each +1 or -1), serve counter, serve_dy.
- IDLE:
  - Ball and paddles hold.
  - start=1 → SERVE, with dx=+1 and serve counter=SERVE_DELAY-1.
- SERVE:
  - Ball is held at (31,31).
  - Paddles move on each tick.
  - On each tick: if counter=0 → PLAY, else counter decrements. The ball does not move on the tick that enters PLAY.
- PLAY, on each tick:
  - Paddles update.
  - Ball updates using the pre-update (registered) paddle positions.
- Paddle update, per paddle:
  - up only: y-1, saturating at 0.
  - down only: y+1, saturating at 64-PADDLE_H (56).
  - both or neither: hold.
- Ball vertical motion:
  - by=0 with dy=-1: dy becomes +1 and by=1.
  - by=63 with dy=+1: dy becomes -1 and by=62.
  - otherwise: by+dy.
- Ball horizontal motion (evaluated in this order):
  - Left paddle check: dx=-1 and bx=P1_X+1. Hit if p1y ≤ by ≤ p1y+PADDLE_H-1 (current by, before this tick's vertical update). Hit: dx=+1, bx=bx+1. Miss: bx=bx-1.
  - Right paddle check: dx=+1 and bx=P2_X-1. Hit test against p2y in the same way. Hit: dx=-1, bx=bx-1. Miss: bx=bx+1.
  - bx=0 with dx=-1: point to P2. bx=63 with dx=+1: point to P1. On a point tick the ball does not move.
  - otherwise: bx+dx.
- Point (takes effect on the same tick):
  - Scorer's score +1.
  - If the new score = WIN_SCORE → OVER, with game_over=1 and winner = scorer.
  - Otherwise → SERVE:
    - ball = (31,31)
    - dx points toward the player who conceded
    - serve_dy toggles, and dy takes the new serve_dy
    - counter = SERVE_DELAY-1
- Scores never exceed WIN_SCORE ≤ 7, so no overflow is possible.
- OVER:
  - Everything holds.
  - start=1 → sc1=sc2=0, game_over=0, ball=(31,31), dx=+1, then SERVE. Paddles keep their positions.
- start is ignored in SERVE and PLAY.
- Button inputs are ignored in IDLE and OVER.
- tick=0 cycles change nothing except the start transitions and reset.

Test Plan:
- Reset: rst_n=0 for 2 clks, then 1 → bx=31, by=31, p1y=p2y=28, sc1=sc2=0, game_over=0. Repeat the reset while in PLAY → same values, state IDLE.
- Serve timing: pulse start, then give 16 ticks → ball stays at (31,31). 17th tick → (32,32). 18th tick → (33,33).
- Paddle saturation: in SERVE, hold p1_up for 40 ticks → p1y=0. Hold p1_dn for 60 ticks → p1y=56. Hold p1_up and p1_dn together → p1y unchanged.
- Miss: paddles idle at 28.
  - PLAY tick 31 (ball at 61,61, miss) → bx=62, by=62.
  - Tick 33 → sc1=1, ball=(31,31), state SERVE, dx=+1, dy=-1.
- Hit: hold p2_dn from start, so p2y=56 by PLAY.
  - PLAY tick 31 → bx=60, by=62, dx=-1.
  - Tick 32 → bx=59, by=63.
  - Tick 33 → by=62 (top/bottom bounce).
- Game over: drive 7 P1 points → on the 7th, game_over=1, winner=0, sc1=7. Further ticks change nothing. start → sc1=sc2=0, game_over=0, SERVE.
